// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter -- iterative AES-128 inverse cipher, one round per clock.
//
// Accepts a ciphertext block plus the round-10 key, runs the initial
// AddRoundKey, nine full inverse rounds and one final inverse round, and
// derives each earlier round key on the fly by stepping the schedule backward.
//
// Optional build macro AES_DEC_KEY_EXPAND_EN: inputKey is the cipher key.
// An EXPAND phase first runs the forward schedule to reach the round-10 key.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   inValid / inReady   ingress handshake; inputData / inputKey sampled at accept
//   outValid / outReady egress handshake; outData held until taken
//   inputData, outData  bits [127:120] are state byte 0 (column-major)

package aes128_dec_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(a3, a3);
    a12  = gmul(a12, a12);
    a240 = gmul(a12, a3);                         // a^15
    for (int i = 0; i < 4; i++) a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// Forward S-box: affine transform of the field inverse.
module aes_sbox import aes128_dec_pkg::*; (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  logic [7:0] w_inv;
  assign w_inv = ginv(i_a);
  assign o_y   = w_inv ^ rl(w_inv, 1) ^ rl(w_inv, 2) ^ rl(w_inv, 3) ^ rl(w_inv, 4) ^ 8'h63;
endmodule

// Inverse S-box: undo the affine transform, then invert in the field.
module aes_inv_sbox import aes128_dec_pkg::*; (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  assign o_y = ginv(rl(i_a, 1) ^ rl(i_a, 3) ^ rl(i_a, 6) ^ 8'h05);
endmodule

module aes128_decrypt_iter import aes128_dec_pkg::*; (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inputKey,
  input  logic [127:0] inputData,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE, EXPAND} fsm_t;

  fsm_t         r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_state, r_rk;
  logic         r_in_ready, r_out_valid;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3, w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_sw_in, w_rot, w_sw, w_rc;
  logic [127:0] w_p, w_isb, w_ark, w_imc;

  assign {w_k0, w_k1, w_k2, w_k3} = r_rk;

  // Backward key step: recover the previous round key from the current one.
  assign w_p3 = w_k3 ^ w_k2;
  assign w_p2 = w_k2 ^ w_k1;
  assign w_p1 = w_k1 ^ w_k0;
  assign w_rc = {rcon(r_rnd + 4'd1), 24'h0};
  assign w_p0 = w_k0 ^ w_sw ^ w_rc;
  assign w_p  = {w_p0, w_p1, w_p2, w_p3};

`ifdef AES_DEC_KEY_EXPAND_EN
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  // The forward schedule shares the four SubWord S-boxes with the backward step.
  assign w_sw_in = (r_fsm == EXPAND) ? w_k3 : w_p3;
  assign w_f0    = w_k0 ^ w_sw ^ w_rc;
  assign w_f1    = w_k1 ^ w_f0;
  assign w_f2    = w_k2 ^ w_f1;
  assign w_f3    = w_k3 ^ w_f2;
`else
  assign w_sw_in = w_p3;
`endif
  assign w_rot = {w_sw_in[23:0], w_sw_in[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_subword
    aes_sbox u_sb (.i_a(w_rot[31-8*k -: 8]), .o_y(w_sw[31-8*k -: 8]));
  end

  // InvShiftRows is pure wiring: output byte (row r, col c) takes col (c-r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    aes_inv_sbox u_isb (.i_a(r_state[127-8*SRC -: 8]), .o_y(w_isb[127-8*i -: 8]));
  end

  assign w_ark = w_isb ^ w_p;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*c -: 8];
    assign w_a1 = w_ark[119-32*c -: 8];
    assign w_a2 = w_ark[111-32*c -: 8];
    assign w_a3 = w_ark[103-32*c -: 8];
    assign w_imc[127-32*c -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
    assign w_imc[119-32*c -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
    assign w_imc[111-32*c -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
    assign w_imc[103-32*c -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fsm       <= IDLE;
      r_rnd       <= 4'd0;
      r_state     <= '0;
      r_rk        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: if (inValid) begin
          r_in_ready <= 1'b0;
          r_rk       <= inputKey;
`ifdef AES_DEC_KEY_EXPAND_EN
          r_state    <= inputData;
          r_rnd      <= 4'd0;
          r_fsm      <= EXPAND;
`else
          r_state    <= inputData ^ inputKey;
          r_rnd      <= 4'd9;
          r_fsm      <= ROUND;
`endif
        end
`ifdef AES_DEC_KEY_EXPAND_EN
        // r_rnd counts forward steps 0..9; the 11th cycle whitens with rk10.
        EXPAND: if (r_rnd == 4'd10) begin
          r_state <= r_state ^ r_rk;
          r_rnd   <= 4'd9;
          r_fsm   <= ROUND;
        end else begin
          r_rk  <= {w_f0, w_f1, w_f2, w_f3};
          r_rnd <= r_rnd + 4'd1;
        end
`endif
        ROUND: begin
          r_rk <= w_p;
          if (r_rnd == 4'd0) begin
            r_state     <= w_ark;
            r_out_valid <= 1'b1;
            r_fsm       <= DONE;
          end else begin
            r_state <= w_imc;
            r_rnd   <= r_rnd - 4'd1;
          end
        end
        DONE: if (outReady) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_fsm       <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign outData  = r_state;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter. The reference is a forward AES-128 encryptor:
// random (key, plaintext) pairs are encrypted here, the ciphertext is fed in,
// and the plaintext must come back with the expected latency and handshakes.
module tb_aes128_decrypt_iter;
`ifdef AES_DEC_KEY_EXPAND_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 10;
`endif
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         CLK = 1'b0, RST_N = 1'b0, inValid = 1'b0, outReady = 1'b0;
  logic [127:0] inputKey = '0, inputData = '0;
  logic         inReady, outValid;
  logic [127:0] outData;

  aes128_decrypt_iter dut (
    .CLK(CLK), .RST_N(RST_N), .inValid(inValid), .inReady(inReady),
    .inputKey(inputKey), .inputData(inputData), .outValid(outValid),
    .outReady(outReady), .outData(outData)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int           nerr = 0, nchk = 0, hs_cnt = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           acc_log [$];
  logic [127:0] cur_pt = '0;
  bit           rand_mode = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Forward S-box table built by walking generator 3 of GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Textbook AES-128 encryption; also returns the round-10 key.
  task automatic aes_enc(input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct, output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int i = 0; i < 16; i++) s[i] = u[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  // Single compare process: expected outValid/inReady/outData follow from the
  // queue of accepted blocks and their accept cycles.
  always @(negedge CLK) begin
    bit ev;
    if (!RST_N) begin
      exp_q.delete();
      acc_q.delete();
      chk(outValid == 1'b0, "rst_outValid", {127'd0, outValid}, 128'd0);
      chk(outData == '0, "rst_outData", outData, 128'd0);
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= acc_q[0] + LAT);
      chk(outValid === ev, "outValid", {127'd0, outValid}, {127'd0, ev});
      chk(inReady === (exp_q.size() == 0), "inReady", {127'd0, inReady}, {127'd0, exp_q.size() == 0});
      if (ev) chk(outData === exp_q[0], "outData", outData, exp_q[0]);
      if (ev && outValid && outReady) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        hs_cnt++;
      end else if (inValid && inReady) begin
        exp_q.push_back(cur_pt);
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [127:0] key, input logic [127:0] pt, input bit keep);
    logic [127:0] ct, rk10;
    bit           acc;
    int           n;
    aes_enc(key, pt, ct, rk10);
    inputData = ct;
`ifdef AES_DEC_KEY_EXPAND_EN
    inputKey  = key;
`else
    inputKey  = rk10;
`endif
    cur_pt  = pt;
    inValid = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      acc = inValid && inReady && RST_N;
      @(posedge CLK); #1;
      if (rand_mode) outReady = 1'($urandom_range(0, 1));
      if (acc) break;
      n++;
      if (n > 200) begin
        nchk++; nerr++;
        $display("FAIL accept_timeout: no accept within %0d cycles", n);
        break;
      end
    end
    if (!keep) inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge CLK); #1;
      n++;
      if (n > 400) begin
        nchk++; nerr++;
        $display("FAIL drain_timeout: %0d blocks pending after %0d cycles", exp_q.size(), n);
        break;
      end
    end
  endtask

  initial begin
    logic [127:0] ct, rk;
    int a0, h0, n;
    build_sbox();
    chk(sb[8'h00] == 8'h63, "model_sb00", {120'd0, sb[8'h00]}, 128'h63);
    chk(sb[8'h01] == 8'h7c, "model_sb01", {120'd0, sb[8'h01]}, 128'h7c);
    chk(sb[8'h53] == 8'hed, "model_sb53", {120'd0, sb[8'h53]}, 128'hed);
    aes_enc(K_C1, P_C1, ct, rk);
    chk(ct == 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "model_c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk(rk == 128'h13111d7fe3944a17f307a78b4d2b30c5, "model_c1_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    aes_enc(K_B, P_B, ct, rk);
    chk(ct == 128'h3925841d02dc09fbdc118597196a0b32, "model_b_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
    chk(rk == 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "model_b_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    outReady = 1'b1;

    // Known-answer vectors.
    send(K_C1, P_C1, 1'b0); wait_idle();
    send(K_B, P_B, 1'b0);   wait_idle();

    // Backpressure: hold the result 50 cycles while offering a competing block.
    outReady = 1'b0;
    send(K_C1, P_C1, 1'b0);
    n = 0;
    while (!outValid && n < 100) begin @(posedge CLK); #1; n++; end
    chk(outValid == 1'b1, "bp_outValid_seen", {127'd0, outValid}, 128'd1);
    a0 = acc_log.size();
    h0 = hs_cnt;
    repeat (50) begin
      inValid   = 1'b1;
      inputData = {$urandom, $urandom, $urandom, $urandom};
      cur_pt    = ~P_C1;
      @(posedge CLK); #1;
    end
    inValid = 1'b0;
    chk(acc_log.size() == a0, "bp_no_accept", 128'(acc_log.size()), 128'(a0));
    chk(hs_cnt == h0, "bp_no_handshake", 128'(hs_cnt), 128'(h0));
    outReady = 1'b1;
    @(posedge CLK); #1;
    chk(hs_cnt == h0 + 1, "bp_one_handshake", 128'(hs_cnt), 128'(h0 + 1));
    chk(inReady == 1'b1, "bp_inReady_after", {127'd0, inReady}, 128'd1);
    wait_idle();

    // Reset five cycles into a block, then decrypt C.1 cleanly.
    send(K_C1, P_C1, 1'b0);
    repeat (5) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk(outValid == 1'b0, "midrst_outValid", {127'd0, outValid}, 128'd0);
    chk(outData == '0, "midrst_outData", outData, 128'd0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk(inReady == 1'b1, "midrst_inReady", {127'd0, inReady}, 128'd1);
    send(K_C1, P_C1, 1'b0); wait_idle();

    // Back-to-back with inValid and outReady held high.
    send(K_C1, P_C1, 1'b1);
    send(K_B, P_B, 1'b0);
    wait_idle();
    n = acc_log.size();
    chk(acc_log[n-1] - acc_log[n-2] == LAT + 2, "b2b_spacing",
        128'(acc_log[n-1] - acc_log[n-2]), 128'(LAT + 2));

    // Random blocks with random gaps and random output backpressure.
    rand_mode = 1'b1;
    repeat (16) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
        outReady = 1'($urandom_range(0, 1));
      end
    end
    rand_mode = 1'b0;
    outReady = 1'b1;
    wait_idle();

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog expired");
  end
endmodule
